// File: rtl/periph_cmd_master.sv
// -----------------------------------------------------------------------------
// periph_cmd_master
//
// Turns single commands (write, read, or read-poll) into transactions on an
// XBAR_PERIPH_BUS style master port and returns one result per command.
//
// One command is in flight at a time. A poll command keeps re-reading the same
// address until (rdata & mask) == (match & mask), the bus reports an error, or
// POLL_MAX attempts have been made. Between poll attempts the bus is left idle
// for POLL_GAP cycles.
//
// Parameters
//   PER_ID_WIDTH  width of the bus transaction ID
//   MST_ID        ID driven on requests; only responses carrying it are taken
//   POLL_MAX      maximum read attempts per poll command (1..65535)
//   POLL_GAP      idle cycles between poll attempts (0..255)
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cmd_*                  command channel (valid/ready), latched on handshake
//                          cmd_wen_i: 0 = write, 1 = read
//   rsp_*                  result channel (valid/ready)
//                          rsp_rdata_o is 0 for writes
//                          rsp_err_o: the bus returned r_opc=1
//                          rsp_timeout_o: poll gave up after POLL_MAX reads
//   periph_*               peripheral bus master port; periph_wen_o is
//                          active-low (0 = write), be is always 4'hF and id is
//                          always MST_ID
// -----------------------------------------------------------------------------
module periph_cmd_master #(
   parameter int unsigned PER_ID_WIDTH = 5,
   parameter int unsigned MST_ID       = 0,
   parameter int unsigned POLL_MAX     = 1024,
   parameter int unsigned POLL_GAP     = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,

   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic                    cmd_wen_i,
   input  logic [31:0]             cmd_addr_i,
   input  logic [31:0]             cmd_wdata_i,
   input  logic                    cmd_poll_i,
   input  logic [31:0]             cmd_mask_i,
   input  logic [31:0]             cmd_match_i,

   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [31:0]             rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    rsp_timeout_o,

   output logic                    periph_req_o,
   output logic [31:0]             periph_add_o,
   output logic                    periph_wen_o,
   output logic [31:0]             periph_wdata_o,
   output logic [3:0]              periph_be_o,
   output logic [PER_ID_WIDTH-1:0] periph_id_o,
   input  logic                    periph_gnt_i,
   input  logic                    periph_r_valid_i,
   input  logic [31:0]             periph_r_rdata_i,
   input  logic                    periph_r_opc_i,
   input  logic [PER_ID_WIDTH-1:0] periph_r_id_i
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   localparam logic [PER_ID_WIDTH-1:0] OWN_ID   = PER_ID_WIDTH'(MST_ID);
   localparam logic [15:0]             MAX_ATT  = 16'(POLL_MAX);
   // The gap counter runs 0 .. POLL_GAP-1 while in GAP.
   localparam logic [7:0]              GAP_LAST = 8'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

   // ------------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------------
   // Attempt counter saturates instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic poll_hit(input logic [31:0] data,
                                     input logic [31:0] mask,
                                     input logic [31:0] match);
      return (data & mask) == (match & mask);
   endfunction

   // ------------------------------------------------------------------------
   // State and latched command
   // ------------------------------------------------------------------------
   logic [2:0]  state_q, state_d;
   logic        rd_q;        // 1 = read; doubles as the active-low bus wen
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        poll_q;      // already qualified with "is a read"
   logic [31:0] mask_q;
   logic [31:0] match_q;
   logic [15:0] att_q;
   logic [7:0]  gap_q;
   logic        err_q;
   logic        tout_q;
   logic [31:0] rdata_q;

   // ------------------------------------------------------------------------
   // Response evaluation (combinational, used only in WAIT)
   // ------------------------------------------------------------------------
   logic        cmd_hs;
   logic        rsp_hit;
   logic        err_nxt;
   logic [31:0] rsp_data;
   logic        finish_now;
   logic        exhausted;

   assign cmd_hs    = (state_q == S_IDLE) && cmd_valid_i;
   // Responses with a foreign ID belong to another master on the crossbar.
   assign rsp_hit   = (state_q == S_WAIT) && periph_r_valid_i && (periph_r_id_i == OWN_ID);
   assign err_nxt   = err_q | periph_r_opc_i;
   assign rsp_data  = rd_q ? periph_r_rdata_i : 32'h0;
   // An error ends a poll early: re-reading a faulting address is pointless.
   assign finish_now = !rd_q || !poll_q || err_nxt || poll_hit(rsp_data, mask_q, match_q);
   assign exhausted = (att_q == MAX_ATT);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) state_d = S_REQ;
         end
         S_REQ: begin
            if (periph_gnt_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (rsp_hit) begin
               if (finish_now || exhausted) state_d = S_RESP;
               else if (POLL_GAP == 0)      state_d = S_REQ;
               else                         state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) state_d = S_REQ;
         end
         S_RESP: begin
            if (rsp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         rd_q    <= 1'b1;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         poll_q  <= 1'b0;
         mask_q  <= 32'h0;
         match_q <= 32'h0;
         att_q   <= 16'h0;
         gap_q   <= 8'h0;
         err_q   <= 1'b0;
         tout_q  <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;

         if (cmd_hs) begin
            rd_q    <= cmd_wen_i;
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
            // A poll request on a write is just a write.
            poll_q  <= cmd_poll_i & cmd_wen_i;
            mask_q  <= cmd_mask_i;
            match_q <= cmd_match_i;
            att_q   <= 16'h0;
            gap_q   <= 8'h0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
            rdata_q <= 32'h0;
         end

         if ((state_q == S_REQ) && periph_gnt_i) begin
            att_q <= sat_inc16(att_q);
         end

         if (rsp_hit) begin
            rdata_q <= rsp_data;
            err_q   <= err_nxt;
            gap_q   <= 8'h0;
            if (!finish_now && exhausted) tout_q <= 1'b1;
         end

         if (state_q == S_GAP) begin
            gap_q <= gap_q + 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign cmd_ready_o    = (state_q == S_IDLE);
   assign rsp_valid_o    = (state_q == S_RESP);
   assign rsp_rdata_o    = rdata_q;
   assign rsp_err_o      = err_q;
   assign rsp_timeout_o  = tout_q;

   assign periph_req_o   = (state_q == S_REQ);
   assign periph_add_o   = addr_q;
   assign periph_wen_o   = rd_q;
   assign periph_wdata_o = wdata_q;
   assign periph_be_o    = 4'hF;
   assign periph_id_o    = OWN_ID;

endmodule

// File: tb/tb_periph_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_periph_cmd_master
//
// Drives directed and randomized commands into periph_cmd_master while acting
// as the bus slave. Each command carries a per-attempt plan (slave data, error
// bit, grant delay, response latency, foreign-ID and stray-response injection).
// A reference model applies the command rules to the plan to predict the
// number of bus attempts and the final result.
// -----------------------------------------------------------------------------
module tb_periph_cmd_master;

   localparam int IDW   = 5;
   localparam int MST   = 3;
   localparam int P_MAX = 4;
   localparam int P_GAP = 2;
   localparam int BOUND = 40;
   localparam logic [IDW-1:0] MST_ID_V = 5'd3;
   localparam logic [IDW-1:0] FOREIGN  = 5'd9;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            cmd_valid_i;
   logic            cmd_ready_o;
   logic            cmd_wen_i;
   logic [31:0]     cmd_addr_i;
   logic [31:0]     cmd_wdata_i;
   logic            cmd_poll_i;
   logic [31:0]     cmd_mask_i;
   logic [31:0]     cmd_match_i;
   logic            rsp_valid_o;
   logic            rsp_ready_i;
   logic [31:0]     rsp_rdata_o;
   logic            rsp_err_o;
   logic            rsp_timeout_o;
   logic            periph_req_o;
   logic [31:0]     periph_add_o;
   logic            periph_wen_o;
   logic [31:0]     periph_wdata_o;
   logic [3:0]      periph_be_o;
   logic [IDW-1:0]  periph_id_o;
   logic            periph_gnt_i;
   logic            periph_r_valid_i;
   logic [31:0]     periph_r_rdata_i;
   logic            periph_r_opc_i;
   logic [IDW-1:0]  periph_r_id_i;

   periph_cmd_master #(
      .PER_ID_WIDTH (IDW),
      .MST_ID       (MST),
      .POLL_MAX     (P_MAX),
      .POLL_GAP     (P_GAP)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .cmd_valid_i      (cmd_valid_i),
      .cmd_ready_o      (cmd_ready_o),
      .cmd_wen_i        (cmd_wen_i),
      .cmd_addr_i       (cmd_addr_i),
      .cmd_wdata_i      (cmd_wdata_i),
      .cmd_poll_i       (cmd_poll_i),
      .cmd_mask_i       (cmd_mask_i),
      .cmd_match_i      (cmd_match_i),
      .rsp_valid_o      (rsp_valid_o),
      .rsp_ready_i      (rsp_ready_i),
      .rsp_rdata_o      (rsp_rdata_o),
      .rsp_err_o        (rsp_err_o),
      .rsp_timeout_o    (rsp_timeout_o),
      .periph_req_o     (periph_req_o),
      .periph_add_o     (periph_add_o),
      .periph_wen_o     (periph_wen_o),
      .periph_wdata_o   (periph_wdata_o),
      .periph_be_o      (periph_be_o),
      .periph_id_o      (periph_id_o),
      .periph_gnt_i     (periph_gnt_i),
      .periph_r_valid_i (periph_r_valid_i),
      .periph_r_rdata_i (periph_r_rdata_i),
      .periph_r_opc_i   (periph_r_opc_i),
      .periph_r_id_i    (periph_r_id_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Per-attempt slave plan
   logic [31:0] plan_data [8];
   logic        plan_opc  [8];
   int          gdly      [8];
   int          lat       [8];
   bit          foreign   [8];
   bit          stray     [8];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Expected outcome of one command given the current plan.
   function automatic void model(input logic wen, input logic poll,
                                 input logic [31:0] mask, input logic [31:0] match,
                                 output int n, output logic [31:0] rd,
                                 output logic err, output logic to);
      bit done;
      done = 0;
      n = 0; rd = 32'h0; err = 1'b0; to = 1'b0;
      for (int k = 0; k < P_MAX; k++) begin
         if (!done) begin
            n   = k + 1;
            rd  = wen ? plan_data[k] : 32'h0;
            err = err | plan_opc[k];
            if (!wen || !poll || err || ((plan_data[k] & mask) == (match & mask))) done = 1;
            else if (n == P_MAX) begin
               to   = 1'b1;
               done = 1;
            end
         end
      end
   endfunction

   function automatic logic bus_ok(input logic wen, input logic [31:0] addr, input logic [31:0] wdata);
      return periph_req_o && (periph_wen_o == wen) && (periph_add_o == addr) &&
             (periph_wdata_o == wdata) && (periph_be_o == 4'hF) && (periph_id_o == MST_ID_V);
   endfunction

   task automatic check_reset_state();
      chk("rst_cmd_ready", cmd_ready_o, 1);
      chk("rst_req", periph_req_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_err", rsp_err_o, 0);
      chk("rst_timeout", rsp_timeout_o, 0);
      chk("rst_rdata", rsp_rdata_o, 0);
      chk("rst_add", periph_add_o, 0);
      chk("rst_wdata", periph_wdata_o, 0);
      chk("rst_wen", periph_wen_o, 1);
   endtask

   task automatic recover();
      periph_gnt_i = 0; periph_r_valid_i = 0; cmd_valid_i = 0; rsp_ready_i = 0;
      rst_ni = 0;
      tick(); tick();
      rst_ni = 1;
      tick();
   endtask

   task automatic clear_plan();
      for (int k = 0; k < 8; k++) begin
         plan_data[k] = 32'h0; plan_opc[k] = 1'b0;
         gdly[k] = 0; lat[k] = 0; foreign[k] = 0; stray[k] = 0;
      end
   endtask

   task automatic run_cmd(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic poll, input logic [31:0] mask, input logic [31:0] match);
      int          n_exp;
      logic [31:0] e_rd;
      logic        e_err, e_to;
      int          cnt;
      int          stall;
      bit          ok;
      ok = 1;
      model(wen, poll, mask, match, n_exp, e_rd, e_err, e_to);

      cmd_valid_i = 1; cmd_wen_i = wen; cmd_addr_i = addr; cmd_wdata_i = wdata;
      cmd_poll_i = poll; cmd_mask_i = mask; cmd_match_i = match;
      cnt = 0;
      while (!cmd_ready_o && cnt < BOUND) begin tick(); cnt++; end
      chk("cmd_ready", cmd_ready_o, 1);
      if (!cmd_ready_o) ok = 0;
      if (ok) begin
         tick();
         // Scramble command inputs: the DUT must work from its latched copy.
         cmd_valid_i = 0; cmd_wen_i = ~wen; cmd_addr_i = $urandom; cmd_wdata_i = $urandom;
         cmd_poll_i = ~poll; cmd_mask_i = $urandom; cmd_match_i = $urandom;
      end

      for (int a = 0; a < n_exp; a++) begin
         if (ok) begin
            cnt = 0;
            while (!periph_req_o && cnt < BOUND) begin tick(); cnt++; end
            chk("req_start", periph_req_o, 1);
            if (!periph_req_o) ok = 0;
            else if (a == 0) chk("req_latency", cnt, 0);
            else chk("poll_gap", cnt, P_GAP);
         end
         if (ok) begin
            for (int d = 0; d < gdly[a]; d++) begin
               chk("req_hold", bus_ok(wen, addr, wdata), 1);
               if (stray[a]) begin
                  periph_r_valid_i = 1; periph_r_id_i = MST_ID_V;
                  periph_r_rdata_i = $urandom; periph_r_opc_i = 1;
               end
               tick();
               periph_r_valid_i = 0; periph_r_opc_i = 0;
            end
            chk("req_grant", bus_ok(wen, addr, wdata), 1);
            periph_gnt_i = 1;
            tick();
            periph_gnt_i = 0;
            chk("req_drop", periph_req_o, 0);
            for (int l = 0; l < lat[a]; l++) begin
               if (foreign[a]) begin
                  periph_r_valid_i = 1; periph_r_id_i = FOREIGN;
                  periph_r_rdata_i = ~plan_data[a]; periph_r_opc_i = 1;
               end
               chk("wait_quiet", {periph_req_o, rsp_valid_o}, 0);
               tick();
               periph_r_valid_i = 0; periph_r_opc_i = 0; periph_r_id_i = MST_ID_V;
            end
            periph_r_valid_i = 1; periph_r_id_i = MST_ID_V;
            periph_r_rdata_i = plan_data[a]; periph_r_opc_i = plan_opc[a];
            tick();
            periph_r_valid_i = 0; periph_r_opc_i = 0;
         end
      end

      if (ok) begin
         chk("rsp_valid", rsp_valid_o, 1);
         if (!rsp_valid_o) ok = 0;
      end
      if (ok) begin
         chk("rsp_rdata", rsp_rdata_o, e_rd);
         chk("rsp_err", rsp_err_o, e_err);
         chk("rsp_timeout", rsp_timeout_o, e_to);
         chk("rsp_busy", {cmd_ready_o, periph_req_o}, 0);
         stall = $urandom_range(0, 3);
         for (int s = 0; s < stall; s++) begin
            if ($urandom_range(0, 1) == 1) begin
               periph_r_valid_i = 1; periph_r_id_i = MST_ID_V;
               periph_r_rdata_i = $urandom; periph_r_opc_i = 1;
            end
            tick();
            periph_r_valid_i = 0; periph_r_opc_i = 0;
            chk("rsp_hold_flags", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, {1'b1, e_err, e_to});
            chk("rsp_hold_rdata", rsp_rdata_o, e_rd);
         end
         rsp_ready_i = 1;
         tick();
         rsp_ready_i = 0;
         chk("rsp_done", rsp_valid_o, 0);
         chk("idle_ready", cmd_ready_o, 1);
      end
      if (!ok) recover();
   endtask

   initial begin
      logic        w, p;
      logic [31:0] m, mt, d;

      rst_ni = 0;
      cmd_valid_i = 0; cmd_wen_i = 0; cmd_addr_i = 0; cmd_wdata_i = 0;
      cmd_poll_i = 0; cmd_mask_i = 0; cmd_match_i = 0; rsp_ready_i = 0;
      periph_gnt_i = 0; periph_r_valid_i = 0; periph_r_rdata_i = 0;
      periph_r_opc_i = 0; periph_r_id_i = MST_ID_V;
      tick(); tick();
      check_reset_state();
      rst_ni = 1;
      tick();

      // Write with immediate grant
      clear_plan();
      plan_data[0] = 32'hCAFE_F00D;
      run_cmd(1'b0, 32'h1000_0008, 32'h10, 1'b0, 32'h0, 32'h0);

      // Read with grant delayed 3 cycles, data 0x5
      clear_plan();
      gdly[0] = 3; lat[0] = 1; plan_data[0] = 32'h5;
      run_cmd(1'b1, 32'h1000_0000, 32'h0, 1'b0, 32'h0, 32'h0);

      // Poll bit 0: slave returns 0, 0, 1
      clear_plan();
      plan_data[0] = 32'h0; plan_data[1] = 32'h0; plan_data[2] = 32'h1;
      run_cmd(1'b1, 32'h1000_0004, 32'h0, 1'b1, 32'h1, 32'h1);

      // Poll that never matches: POLL_MAX attempts then timeout
      clear_plan();
      run_cmd(1'b1, 32'h1000_0004, 32'h0, 1'b1, 32'h1, 32'h1);

      // Foreign-ID response first, then own response with error
      clear_plan();
      lat[0] = 2; foreign[0] = 1; plan_data[0] = 32'h1234_5678; plan_opc[0] = 1;
      run_cmd(1'b1, 32'h1000_000C, 32'h0, 1'b0, 32'h0, 32'h0);

      // Poll flag on a write behaves as a plain write
      clear_plan();
      plan_data[0] = 32'hFFFF_FFFF;
      run_cmd(1'b0, 32'h1000_0010, 32'hA5A5_0001, 1'b1, 32'h1, 32'h0);

      // Reset while waiting for the response; late response afterwards
      clear_plan();
      cmd_valid_i = 1; cmd_wen_i = 1; cmd_addr_i = 32'h1000_0020; cmd_poll_i = 0;
      tick();
      cmd_valid_i = 0;
      chk("rw_req", periph_req_o, 1);
      periph_gnt_i = 1;
      tick();
      periph_gnt_i = 0;
      rst_ni = 0;
      tick();
      check_reset_state();
      rst_ni = 1;
      periph_r_valid_i = 1; periph_r_id_i = MST_ID_V; periph_r_rdata_i = 32'hDEAD_BEEF;
      tick();
      periph_r_valid_i = 0;
      for (int i = 0; i < 3; i++) begin
         chk("rw_no_rsp", {rsp_valid_o, periph_req_o, cmd_ready_o}, 3'b001);
         chk("rw_rdata", rsp_rdata_o, 0);
         tick();
      end
      clear_plan();
      plan_data[0] = 32'h0000_0077; lat[0] = 1;
      run_cmd(1'b1, 32'h1000_0024, 32'h0, 1'b0, 32'h0, 32'h0);

      // Randomized commands
      for (int i = 0; i < 40; i++) begin
         w  = 1'($urandom_range(0, 1));
         p  = ($urandom_range(0, 3) != 0);
         m  = ($urandom_range(0, 1) == 1) ? (32'h1 << $urandom_range(0, 7)) : $urandom;
         mt = $urandom;
         for (int k = 0; k < 8; k++) begin
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d = (d & ~m) | (mt & m);
            plan_data[k] = d;
            plan_opc[k]  = ($urandom_range(0, 7) == 0);
            gdly[k]      = $urandom_range(0, 3);
            lat[k]       = $urandom_range(0, 3);
            foreign[k]   = ($urandom_range(0, 2) == 0);
            stray[k]     = ($urandom_range(0, 2) == 0);
         end
         run_cmd(w, $urandom, $urandom, p, m, mt);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
